dictionary_loader: RTL
======================

DICTIONARY_LOADER -- requirements
Module: dictionary_loader

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 6, the dictionary index width; DEPTH = 2**KEY_WIDTH entries.
REQ-002 SHALL have parameter VAL_WIDTH, default 12, the uncompressed field width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetn, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port in_valid, input, 1, which marks a valid entry on in_data.
REQ-007 SHALL have port in_data, input, VAL_WIDTH, the next dictionary value in index order.
REQ-008 SHALL have port in_last, input, 1, which marks the final entry supplied; it is qualified by in_valid.
REQ-009 SHALL have port in_ready, output, 1, which indicates the loader accepts an entry this cycle.
REQ-010 SHALL have port write_enable, output, 1, the dictionary write strobe.
REQ-011 SHALL have port write_val, output, VAL_WIDTH, the value written to the dictionary.
REQ-012 SHALL have port busy, output, 1, which is high in FILL and BURST.
REQ-013 SHALL have port done, output, 1, which is high after a completed burst.
REQ-014 SHALL have port entry_count, output, KEY_WIDTH+1, the number of real (non-padded) entries accepted in the last load.

Function
REQ-015 SHALL implement states IDLE, FILL, BURST and DONE.
REQ-016 SHALL move from IDLE or DONE to FILL on start; in the same transition it SHALL clear done, entry_count and the fill index.
REQ-017 SHALL ignore start while in FILL or BURST.
REQ-018 SHALL drive in_ready = 1 only in FILL; an entry is accepted when in_valid and in_ready are both high.
REQ-019 SHALL store each accepted entry in the internal buffer at the fill index, then increment the fill index and entry_count.
REQ-020 SHALL enter BURST on the cycle after it accepts entry DEPTH-1, or after it accepts an entry with in_last = 1, whichever occurs first.
REQ-021 SHALL ignore in_last = 1 when in_valid = 0.
REQ-022 SHALL treat buffer slots not filled before in_last as padding, and SHALL write the value of entry 0 into every padded slot. The dictionary resolves a match to its lowest index, so padding never changes a lookup result.
REQ-023 SHALL, in BURST, drive write_enable = 1 for exactly DEPTH consecutive cycles with no gaps, and SHALL drive write_val = buffer[k] on the k-th cycle, k = 0..DEPTH-1.
REQ-024 SHALL drive write_enable and write_val from registers, with no combinational path from the inputs.
REQ-025 SHALL keep write_enable = 0 for at least one cycle immediately before each burst, so that the dictionary write index restarts at 0.
REQ-026 SHALL enter DONE on the cycle after the last burst write; write_enable SHALL be 0 from that cycle onward.
REQ-027 SHALL hold done = 1 in DONE until the next start.
REQ-028 SHALL hold write_val at its last driven value whenever write_enable = 0.
REQ-029 SHALL size the fill and burst counters at KEY_WIDTH+1 bits; no counter SHALL wrap during a load.
REQ-030 SHALL hold the buffer contents in DONE, and SHALL overwrite them only during a subsequent FILL.

Reset
REQ-031 SHALL, while resetn = 0, asynchronously force state IDLE, in_ready = 0, write_enable = 0, write_val = 0, busy = 0, done = 0, entry_count = 0 and all counters to 0.
REQ-032 SHALL abandon any load interrupted by reset mid-FILL or mid-BURST, with write_enable deasserting immediately; the loader SHALL then wait in IDLE for a new start.
REQ-033 SHALL NOT reset the buffer contents.

Verification
REQ-034 Full load (KEY_WIDTH=6): start, then 64 entries 0x000..0x03F with in_valid held high -> 64 consecutive write_enable cycles with write_val 0x000..0x03F, then done = 1 and entry_count = 64.
REQ-035 Short load: start, then entries 0xA5A, 0x123, 0x7FF with in_last on the third -> burst writes 0xA5A, 0x123, 0x7FF, then 0xA5A for 61 cycles; entry_count = 3.
REQ-036 Bubbled input: in_valid toggles 1/0 throughout FILL -> burst output is still 64 gap-free cycles, and no entry is lost or duplicated.
REQ-037 Start ignored: start pulsed mid-FILL and again mid-BURST -> no state change, and the write sequence is identical to REQ-034.
REQ-038 Reset mid-BURST: resetn low at burst cycle 20 -> write_enable is 0 within the same cycle; after release, state is IDLE and done = 0.
REQ-039 Back-to-back loads: second start in DONE -> done clears, at least one write_enable = 0 cycle precedes the second burst, and a connected dictionary instance reads back the new contents at keys 0, 31 and 63.

Source files
------------

// File: rtl/dictionary_loader.sv
// ============================================================================
// Module   : dictionary_loader
// Purpose  : Collects up to DEPTH dictionary values from a valid/ready stream
//            into a local buffer, then replays the whole buffer to the
//            dictionary as one gap-free burst of DEPTH writes. Slots beyond the
//            last supplied entry are replayed as a copy of entry 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dictionary_loader #(
  parameter int KEY_WIDTH = 6,
  parameter int VAL_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [VAL_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 write_enable,
  output logic [VAL_WIDTH-1:0] write_val,
  output logic                 busy,
  output logic                 done,
  output logic [KEY_WIDTH:0]   entry_count
);

  localparam int DEPTH = 1 << KEY_WIDTH;
  localparam logic [KEY_WIDTH:0] C_LAST  = (KEY_WIDTH+1)'(DEPTH - 1);
  localparam logic [KEY_WIDTH:0] C_DEPTH = (KEY_WIDTH+1)'(DEPTH);
  localparam logic [KEY_WIDTH:0] C_ONE   = (KEY_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   we_q;
  logic [VAL_WIDTH-1:0]   wval_q;
  logic                   busy_q;
  logic                   done_q;
  logic [KEY_WIDTH:0]     count_q;
  logic [KEY_WIDTH:0]     fill_idx_q;
  logic [KEY_WIDTH:0]     burst_idx_q;

  // Buffer is deliberately left out of reset; it is only rewritten in FILL.
  logic [VAL_WIDTH-1:0]   mem_q [DEPTH];

  logic [VAL_WIDTH-1:0]   burst_val_d;
  logic [VAL_WIDTH-1:0]   first_val_d;

  assign in_ready     = in_ready_q;
  assign write_enable = we_q;
  assign write_val    = wval_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign entry_count  = count_q;

  // Burst value selection: slots past the real entries replay entry 0, and the
  // first burst word bypasses the buffer when entry 0 is being accepted now.
  always_comb begin
    burst_val_d = mem_q[0];
    if (burst_idx_q < count_q) begin
      burst_val_d = mem_q[burst_idx_q[KEY_WIDTH-1:0]];
    end
    first_val_d = (fill_idx_q == '0) ? in_data : mem_q[0];
  end

  // Buffer write: store each accepted entry at the current fill index.
  always_ff @(posedge clk) begin
    if (in_ready_q && in_valid) begin
      mem_q[fill_idx_q[KEY_WIDTH-1:0]] <= in_data;
    end
  end

  // Control FSM with registered outputs; the first burst write is issued on
  // the edge that leaves FILL so BURST holds exactly DEPTH write cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      wval_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      fill_idx_q  <= '0;
      burst_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_FILL;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            count_q     <= '0;
            fill_idx_q  <= '0;
            burst_idx_q <= '0;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            fill_idx_q <= fill_idx_q + 1'b1;
            count_q    <= count_q + 1'b1;
            if ((fill_idx_q == C_LAST) || in_last) begin
              state_q     <= S_BURST;
              in_ready_q  <= 1'b0;
              we_q        <= 1'b1;
              wval_q      <= first_val_d;
              burst_idx_q <= C_ONE;
            end
          end
        end
        S_BURST: begin
          if (burst_idx_q == C_DEPTH) begin
            state_q <= S_DONE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wval_q      <= burst_val_d;
            burst_idx_q <= burst_idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
